// File: rtl/four_digit_driver_pkg.sv
// Shared constants for the four-digit scrolling hex display.
// These are the segment patterns, the message ROM and the anode select patterns.
package four_digit_driver_pkg;

   // Active-low segments, bit 6 = a ... bit 0 = g.
   localparam logic [6:0] SEG_TBL [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   localparam logic [3:0] MSG_ROM [16] = '{
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
      4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF
   };

   // Anode vectors ordered {an3, an2, an1, an0}; sel 0 is the leftmost digit.
   localparam logic [3:0] AN_SEL [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
   localparam logic [3:0] AN_OFF     = 4'b1111;

endpackage

// File: rtl/four_digit_driver_if.sv
// Bundle of the display pins: anodes, segments and decimal point, all active-low.
// The driver side uses master and the board or monitor side uses slave.
interface four_digit_driver_if;
   logic an3, an2, an1, an0;
   logic a, b, c, d, e, f, g;
   logic dp;

   modport master (output an3, an2, an1, an0, a, b, c, d, e, f, g, dp);
   modport slave  (input  an3, an2, an1, an0, a, b, c, d, e, f, g, dp);
endinterface

// File: rtl/four_digit_driver_seg7_decoder.sv
// Combinational hex-to-seven-segment decoder with active-low outputs in abcdefg order.
module seg7_decoder
   import four_digit_driver_pkg::*;
(
   input  logic [3:0] chr_i,
   output logic [6:0] seg_o
);
   assign seg_o = SEG_TBL[chr_i];
endmodule

// File: rtl/four_digit_driver.sv
// Multiplexed four-digit display that shows a scrolling 16-character hex message.
// Scrolling is present only when FOUR_DIGIT_DRIVER_SCROLL_EN is defined; otherwise the display shows a static "0123".
module four_digit_driver
   import four_digit_driver_pkg::*;
#(
   parameter int REFRESH_DIV   = 16,
   parameter int SCROLL_FRAMES = 8
) (
   input  logic clk,
   input  logic rst,
   output logic an3,
   output logic an2,
   output logic an1,
   output logic an0,
   output logic a,
   output logic b,
   output logic c,
   output logic d,
   output logic e,
   output logic f,
   output logic g,
   output logic dp
);
   localparam int            CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    sel_q, sel_d;
   logic          cnt_wrap;
   logic [3:0]    ptr;
   logic [3:0]    chr;
   logic [6:0]    seg;
   logic [3:0]    an_q;
   logic [6:0]    seg_q;
   logic          dp_q;

   always_comb begin
      cnt_wrap = (cnt_q == CNT_MAX);
      cnt_d    = cnt_wrap ? '0 : cnt_q + CW'(1);
      sel_d    = cnt_wrap ? sel_q + 2'd1 : sel_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         sel_q <= 2'd0;
      end else begin
         cnt_q <= cnt_d;
         sel_q <= sel_d;
      end
   end

`ifdef FOUR_DIGIT_DRIVER_SCROLL_EN
   localparam int            FW      = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
   localparam logic [FW-1:0] FRM_MAX = FW'(SCROLL_FRAMES - 1);

   logic [FW-1:0] frm_q, frm_d;
   logic [3:0]    ptr_q, ptr_d;

   // A frame ends when the rightmost digit finishes its slot.
   always_comb begin
      frm_d = frm_q;
      ptr_d = ptr_q;
      if (cnt_wrap && (sel_q == 2'd3)) begin
         if (frm_q == FRM_MAX) begin
            frm_d = '0;
            ptr_d = ptr_q + 4'd1;
         end else begin
            frm_d = frm_q + FW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frm_q <= '0;
         ptr_q <= 4'h0;
      end else begin
         frm_q <= frm_d;
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;
`else
   assign ptr = 4'h0;
`endif

   // The 4-bit add wraps naturally, so the message reads circularly.
   assign chr = MSG_ROM[ptr + {2'b00, sel_q}];

   seg7_decoder u_dec (
      .chr_i (chr),
      .seg_o (seg)
   );

   // Anodes, segments and dp share one register stage so that they always switch together.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_q  <= AN_OFF;
         seg_q <= SEG_OFF;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= AN_SEL[sel_q];
         seg_q <= seg;
         dp_q  <= ~((sel_q == 2'd3) && (ptr == 4'h0));
      end
   end

   assign {an3, an2, an1, an0}    = an_q;
   assign {a, b, c, d, e, f, g}   = seg_q;
   assign dp                      = dp_q;
endmodule

// File: tb/tb_four_digit_driver.sv
// Directed bench for four_digit_driver: table vectors at chosen edges, a per-edge reference model, and a reset-pulse sequence.
module tb_four_digit_driver;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   four_digit_driver_if dif ();

   four_digit_driver dut (
      .clk (clk), .rst (rst),
      .an3 (dif.an3), .an2 (dif.an2), .an1 (dif.an1), .an0 (dif.an0),
      .a (dif.a), .b (dif.b), .c (dif.c), .d (dif.d),
      .e (dif.e), .f (dif.f), .g (dif.g), .dp (dif.dp)
   );

   always #5 clk = ~clk;

`ifdef FOUR_DIGIT_DRIVER_SCROLL_EN
   localparam bit SCROLL = 1'b1;
`else
   localparam bit SCROLL = 1'b0;
`endif

   typedef struct {
      int         edge_n;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } vec_t;

   logic [6:0] seg_ref [16];
   vec_t       vecs [11];

   function automatic logic [11:0] dut_out();
      return {dif.an3, dif.an2, dif.an1, dif.an0,
              dif.a, dif.b, dif.c, dif.d, dif.e, dif.f, dif.g, dif.dp};
   endfunction

   task automatic check(input string name, input int en, input logic [11:0] want);
      logic [11:0] got;
      got = dut_out();
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s edge %0d: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                  name, en, got[11:8], got[7:1], got[0], want[11:8], want[7:1], want[0]);
      end
   endtask

   // Reference for edge e (where edge 1 is the first edge after reset is released).
   function automatic logic [11:0] model(input int en);
      int t, sel, ptr, ch;
      logic [3:0] an;
      t   = en - 1;
      sel = (t / 16) % 4;
      ptr = SCROLL ? (t / 512) % 16 : 0;
      ch  = (ptr + sel) % 16;
      an  = ~(4'b1000 >> sel);
      return {an, seg_ref[ch], !((sel == 3) && (ptr == 0))};
   endfunction

   task automatic hold_reset(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         check("reset_dark", 0, 12'hFFF);
      end
      rst = 1'b0;
   endtask

   initial begin
      seg_ref = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
      vecs[0] = '{1,  4'b0111, 7'b0000001, 1'b1};
      vecs[1] = '{16, 4'b0111, 7'b0000001, 1'b1};
      vecs[2] = '{17, 4'b1011, 7'b1001111, 1'b1};
      vecs[3] = '{32, 4'b1011, 7'b1001111, 1'b1};
      vecs[4] = '{33, 4'b1101, 7'b0010010, 1'b1};
      vecs[5] = '{49, 4'b1110, 7'b0000110, 1'b0};
      vecs[6] = '{64, 4'b1110, 7'b0000110, 1'b0};
      vecs[7] = '{65, 4'b0111, 7'b0000001, 1'b1};
      if (SCROLL) begin
         vecs[8]  = '{513,  4'b0111, 7'b1001111, 1'b1};
         vecs[9]  = '{561,  4'b1110, 7'b1001100, 1'b1};
         vecs[10] = '{8193, 4'b0111, 7'b0000001, 1'b1};
      end else begin
         vecs[8]  = '{513,  4'b0111, 7'b0000001, 1'b1};
         vecs[9]  = '{561,  4'b1110, 7'b0000110, 1'b0};
         vecs[10] = '{8193, 4'b0111, 7'b0000001, 1'b1};
      end

      hold_reset(5);

      // Long run: table vectors at their edges, the model on every edge.
      for (int en = 1; en <= 8200; en++) begin
         logic [11:0] want;
         @(posedge clk); #1;
         for (int k = 0; k < 11; k++)
            if (vecs[k].edge_n == en) begin
               want = {vecs[k].an, vecs[k].seg, vecs[k].dp};
               check("table", en, want);
            end
         if (en == 8192 && SCROLL) check("ptr_F_last", en, {4'b1110, 7'b0010010, 1'b1});
         check("model", en, model(en));
      end

      // Restart, then pulse reset for one cycle at edge 300.
      hold_reset(2);
      for (int en = 1; en <= 299; en++) begin
         @(posedge clk); #1;
      end
      check("pre_pulse", 299, model(299));
      rst = 1'b1;
      @(posedge clk); #1;
      check("pulse_dark", 300, 12'hFFF);
      rst = 1'b0;
      for (int en = 1; en <= 80; en++) begin
         @(posedge clk); #1;
         check("after_pulse", en, model(en));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/four_digit_driver.md
FOUR_DIGIT_DRIVER -- requirements
Module: four_digit_driver

Interface
REQ-001 SHALL: parameter REFRESH_DIV, default 16, clock cycles each digit stays selected (>=2).
REQ-002 SHALL: parameter SCROLL_FRAMES, default 8, full 4-digit refresh frames per scroll step (>=1).
REQ-003 SHALL: clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL: an3, an2, an1, an0  output  1 each  digit anodes, active-low; an3 leftmost, an0 rightmost.
REQ-006 SHALL: a, b, c, d, e, f, g  output  1 each  segment cathodes, active-low; e is an output port even where a parent leaves it unconnected.
REQ-007 SHALL: dp  output  1  decimal point, active-low.

Function
REQ-008 SHALL: state = refresh counter cnt (0..REFRESH_DIV-1), digit select sel (2 bits), frame counter frm (0..SCROLL_FRAMES-1), message pointer ptr (4 bits).
REQ-009 SHALL: cnt increments every cycle and wraps to 0 after REFRESH_DIV-1; sel increments mod 4 on each cnt wrap.
REQ-010 SHALL: frm increments on a cnt wrap with sel==3 and wraps after SCROLL_FRAMES-1; ptr increments mod 16 on that frm wrap (0xF wraps to 0x0).
REQ-011 SHALL: sel==k drives anode an(3-k) low and all others high; exactly one anode is low outside reset.
REQ-012 SHALL: digit k shows message character (ptr+k) mod 16; message ROM entry i = hex value i (0..F).
REQ-013 SHALL: characters decoded to active-low segments, order abcdefg: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-014 SHALL: dp driven low only while an0 is selected and ptr==0 (marks message start), high otherwise.
REQ-015 SHALL: all outputs registered; values at edge n reflect sel/ptr held before edge n (one-cycle latency), so anodes and segments always change on the same edge.

Reset
REQ-016 SHALL: while rst is sampled high, cnt, sel, frm, ptr clear to 0 and all anodes, segments and dp register 1 (display dark).
REQ-017 SHALL: reset asserted mid-frame or mid-scroll takes effect at the next edge with no partial update; the first edge with rst low shows an3 low, character 0.

Configuration
REQ-018 SHALL: macro FOUR_DIGIT_DRIVER_SCROLL_EN defined: scrolling per REQ-010.
REQ-019 SHALL: macro undefined: frm and ptr absent, ptr fixed 0, display static "0123" (dp lit on an0 per REQ-014), all other behaviour unchanged.

Structure
REQ-020 SHALL: package four_digit_driver_pkg holds the 16-entry segment-pattern constant table, message ROM contents and anode-pattern constants.
REQ-021 SHALL: one combinational sub-module seg7_decoder (4-bit char in, 7-bit active-low abcdefg out) instantiated once; counters, mux and output registers in the top.

Verification (defaults, SCROLL_EN defined, edge 1 = first edge after rst low)
REQ-022 SHALL: rst high 5 cycles -> an3..an0=1111, abcdefg=1111111, dp=1 throughout.
REQ-023 SHALL: edges 1-16 -> an3=0 others 1, abcdefg=0000001; edges 17-32 -> an2=0, 1001111; edges 49-64 -> an0=0, 0000110, dp=0.
REQ-024 SHALL: edge 513 -> an3=0 showing 1 (1001111); edge 561 -> an0=0 showing 4 (1001100), dp=1.
REQ-025 SHALL: run 8192 cycles -> ptr wraps F->0; edge 8193 shows an3=0 with 0000001.
REQ-026 SHALL: rst pulsed 1 cycle at edge 300 -> next edge dark, following edge an3=0 with 0000001, counters restart.
REQ-027 SHALL: build without SCROLL_EN, run 2000 cycles -> every frame shows 0,1,2,3 on an3..an0, never changes.
